// File: rtl/v74x148_pkg.sv
// Shared types and constants for the v74x148 request encoder.
package v74x148_pkg;

   localparam int unsigned N_REQ  = 8;
   localparam int unsigned CODE_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CODE_W-1:0] A_L_RST  = 3'b111;
   localparam logic [N_REQ-1:0]  SYNC_RST = '1;

endpackage

// File: rtl/sync_ff.sv
// N-bit multi-stage synchronizer; reset drives every stage to the inactive (all ones) level.
module sync_ff #(
   parameter int unsigned N      = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] stage [STAGES];

   // Shift the asynchronous input through STAGES flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(STAGES); i++) stage[i] <= {N{1'b1}};
      end else begin
         stage[0] <= d;
         for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/v74x148_irq_encoder.sv
// Registered 8-input priority encoder with valid/ack handshake and per-line service masking.
module v74x148_irq_encoder
   import v74x148_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              EI_L,
   input  logic [N_REQ-1:0]  I_L,
   input  logic              ACK,
   output logic [CODE_W-1:0] A_L,
   output logic              VALID,
   output logic              GS_L,
   output logic              EO_L
);

   state_t             state, state_nxt;
   logic [N_REQ-1:0]   i_l_sync;
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   pend;
   logic [N_REQ-1:0]   mask, mask_nxt;
   logic [N_REQ-1:0]   set_bit;
   logic [CODE_W-1:0]  win;
   logic [CODE_W-1:0]  held_idx;
   logic [CODE_W-1:0]  a_l_nxt;
   logic               valid_nxt;
   logic               gs_l_nxt;
   logic               eo_l_nxt;

   // Highest set bit wins; later iterations override lower indices.
   function automatic logic [CODE_W-1:0] prio_win(input logic [N_REQ-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (v[i]) idx = CODE_W'(i);
      end
      return idx;
   endfunction

   sync_ff #(
      .N      (N_REQ),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (CLK),
      .reset (RESET),
      .d     (I_L),
      .q     (i_l_sync)
   );

   assign req      = ~i_l_sync;
   assign pend     = req & ~mask;
   assign win      = prio_win(pend);
   assign held_idx = ~A_L;

   // Next-state, capture/retire, mask and flag computation.
   always_comb begin
      state_nxt = state;
      a_l_nxt   = A_L;
      valid_nxt = VALID;
      set_bit   = '0;
      unique case (state)
         IDLE: begin
            valid_nxt = 1'b0;
            if (!EI_L && (pend != '0)) begin
               a_l_nxt   = ~win;
               valid_nxt = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (ACK) begin
               valid_nxt         = 1'b0;
               set_bit[held_idx] = 1'b1;
               state_nxt         = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
      // A mask bit only survives while its line stays asserted.
      mask_nxt = (mask | set_bit) & req;
      gs_l_nxt = ~(!EI_L && (pend != '0));
      eo_l_nxt = ~(!EI_L && (req == '0));
   end

   // State, held code, mask and flag registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         A_L   <= A_L_RST;
         VALID <= 1'b0;
         GS_L  <= 1'b1;
         EO_L  <= 1'b1;
         mask  <= '0;
      end else begin
         state <= state_nxt;
         A_L   <= a_l_nxt;
         VALID <= valid_nxt;
         GS_L  <= gs_l_nxt;
         EO_L  <= eo_l_nxt;
         mask  <= mask_nxt;
      end
   end

endmodule

// File: tb/tb_v74x148_irq_encoder.sv
// Bench for v74x148_irq_encoder: directed scenarios plus random traffic against a reference model.
module tb_v74x148_irq_encoder;

   localparam int unsigned SS = 2;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       EI_L;
   logic [7:0] I_L;
   logic       ACK;
   logic [2:0] A_L;
   logic       VALID;
   logic       GS_L;
   logic       EO_L;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [7:0] m_q[$];
   bit         m_valid;
   int         m_code;
   bit [7:0]   m_served;
   bit         m_gs;
   bit         m_eo;

   v74x148_irq_encoder #(.SYNC_STAGES(SS)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .EI_L  (EI_L),
      .I_L   (I_L),
      .ACK   (ACK),
      .A_L   (A_L),
      .VALID (VALID),
      .GS_L  (GS_L),
      .EO_L  (EO_L)
   );

   always #5 CLK = ~CLK;

   function automatic int highest(input bit [7:0] v);
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   // One clock edge of the behavioural model.
   function void model_edge(input bit rst, input bit ei, input logic [7:0] il, input bit ack);
      bit [7:0] req;
      bit [7:0] pend;
      int       acked;
      if (rst) begin
         m_q.delete();
         for (int i = 0; i < int'(SS); i++) m_q.push_back(8'hFF);
         m_valid  = 0;
         m_code   = 0;
         m_served = '0;
         m_gs     = 1;
         m_eo     = 1;
         return;
      end
      req   = ~m_q[0];
      pend  = req & ~m_served;
      acked = -1;
      if (m_valid) begin
         if (ack) begin
            m_valid = 0;
            acked   = m_code;
         end
      end else if (!ei && pend != 0) begin
         m_valid = 1;
         m_code  = highest(pend);
      end
      for (int i = 0; i < 8; i++) m_served[i] = req[i] && (m_served[i] || i == acked);
      m_gs = !(!ei && pend != 0);
      m_eo = !(!ei && req == 0);
      m_q.push_back(il);
      void'(m_q.pop_front());
   endfunction

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         bit rst, ei, ack;
         logic [7:0] il;
         rst = RESET; ei = EI_L; ack = ACK; il = I_L;
         @(posedge CLK);
         model_edge(rst, ei, il, ack);
         #1;
      end
   endtask

   task automatic test_reset();
      RESET = 1; EI_L = 0; ACK = 0; I_L = 8'hFF;
      step(2);
      total++; if (VALID !== 1'b0 || A_L !== 3'b111 || GS_L !== 1'b1 || EO_L !== 1'b1) begin
         bad++; $display("FAIL reset_hold got v=%b a=%b gs=%b eo=%b exp v=0 a=111 gs=1 eo=1", VALID, A_L, GS_L, EO_L);
      end
      RESET = 0;
      step(3);
      total++; if (VALID !== 1'b0 || A_L !== 3'b111 || GS_L !== 1'b1 || EO_L !== 1'b0) begin
         bad++; $display("FAIL reset_idle got v=%b a=%b gs=%b eo=%b exp v=0 a=111 gs=1 eo=0", VALID, A_L, GS_L, EO_L);
      end
   endtask

   task automatic test_priority();
      I_L = 8'b1101_0111;
      step(2);
      total++; if (VALID !== 1'b0) begin bad++; $display("FAIL prio_latency got=%b exp=0", VALID); end
      step(1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b010) begin
         bad++; $display("FAIL prio_first got v=%b a=%b exp v=1 a=010", VALID, A_L);
      end
      ACK = 1; step(1);
      total++; if (VALID !== 1'b0) begin bad++; $display("FAIL prio_retire got=%b exp=0", VALID); end
      ACK = 0; step(1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b100) begin
         bad++; $display("FAIL prio_second got v=%b a=%b exp v=1 a=100", VALID, A_L);
      end
      ACK = 1; step(1); ACK = 0;
      for (int k = 0; k < 4; k++) begin
         step(1);
         total++; if (VALID !== 1'b0 || GS_L !== 1'b1) begin
            bad++; $display("FAIL prio_masked got v=%b gs=%b exp v=0 gs=1", VALID, GS_L);
         end
      end
      I_L = 8'hFF; step(SS + 1);
      I_L = 8'b1101_1111; step(SS + 1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b010) begin
         bad++; $display("FAIL prio_rereport got v=%b a=%b exp v=1 a=010", VALID, A_L);
      end
      ACK = 1; step(1); ACK = 0; I_L = 8'hFF; step(SS + 2);
   endtask

   task automatic test_hold_release();
      I_L = 8'b1101_1111; step(SS + 1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b010) begin
         bad++; $display("FAIL hold_capture got v=%b a=%b exp v=1 a=010", VALID, A_L);
      end
      I_L = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         step(1);
         total++; if (VALID !== 1'b1 || A_L !== 3'b010) begin
            bad++; $display("FAIL hold_frozen got v=%b a=%b exp v=1 a=010", VALID, A_L);
         end
      end
      ACK = 1; step(1); ACK = 0;
      total++; if (VALID !== 1'b0) begin bad++; $display("FAIL hold_ack got=%b exp=0", VALID); end
      I_L = 8'b1101_1111; step(SS + 1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b010) begin
         bad++; $display("FAIL hold_unmasked got v=%b a=%b exp v=1 a=010", VALID, A_L);
      end
      ACK = 1; step(1); ACK = 0; I_L = 8'hFF; step(SS + 2);
   endtask

   task automatic test_enable();
      EI_L = 1; I_L = 8'h7F;
      for (int k = 0; k < 4; k++) begin
         step(1);
         total++; if (VALID !== 1'b0 || GS_L !== 1'b1 || EO_L !== 1'b1) begin
            bad++; $display("FAIL en_blocked got v=%b gs=%b eo=%b exp v=0 gs=1 eo=1", VALID, GS_L, EO_L);
         end
      end
      EI_L = 0; step(1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b000 || GS_L !== 1'b0) begin
         bad++; $display("FAIL en_release got v=%b a=%b gs=%b exp v=1 a=000 gs=0", VALID, A_L, GS_L);
      end
      ACK = 1; step(1); ACK = 0; I_L = 8'hFF; step(SS + 2);
   endtask

   task automatic test_back_to_back();
      I_L = 8'hFE; step(SS + 1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b111) begin
         bad++; $display("FAIL b2b_line0 got v=%b a=%b exp v=1 a=111", VALID, A_L);
      end
      I_L = 8'h7E; step(SS);
      total++; if (VALID !== 1'b1 || A_L !== 3'b111) begin
         bad++; $display("FAIL b2b_still_held got v=%b a=%b exp v=1 a=111", VALID, A_L);
      end
      ACK = 1; step(1); ACK = 0;
      total++; if (VALID !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", VALID); end
      step(1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b000) begin
         bad++; $display("FAIL b2b_line7 got v=%b a=%b exp v=1 a=000", VALID, A_L);
      end
      ACK = 1; step(1); ACK = 0; I_L = 8'hFF; step(SS + 2);
   endtask

   task automatic test_reset_in_hold();
      I_L = 8'hEF; step(SS + 1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b011) begin
         bad++; $display("FAIL rst_hold_capture got v=%b a=%b exp v=1 a=011", VALID, A_L);
      end
      RESET = 1; step(1); RESET = 0;
      total++; if (VALID !== 1'b0 || A_L !== 3'b111 || GS_L !== 1'b1 || EO_L !== 1'b1) begin
         bad++; $display("FAIL rst_hold_clear got v=%b a=%b gs=%b eo=%b exp v=0 a=111 gs=1 eo=1", VALID, A_L, GS_L, EO_L);
      end
      step(SS);
      total++; if (VALID !== 1'b0) begin bad++; $display("FAIL rst_hold_early got=%b exp=0", VALID); end
      step(1);
      total++; if (VALID !== 1'b1 || A_L !== 3'b011) begin
         bad++; $display("FAIL rst_hold_recapture got v=%b a=%b exp v=1 a=011", VALID, A_L);
      end
      ACK = 1; step(1); ACK = 0; I_L = 8'hFF; step(SS + 2);
   endtask

   task automatic test_random();
      logic [2:0] exp_al;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 3) == 0) I_L = 8'($urandom | $urandom);
         EI_L  = ($urandom_range(0, 7) == 0);
         ACK   = ($urandom_range(0, 2) == 0);
         RESET = ($urandom_range(0, 99) == 0);
         step(1);
         exp_al = 3'(7 - m_code);
         total++;
         if (VALID !== m_valid || A_L !== exp_al || GS_L !== m_gs || EO_L !== m_eo) begin
            bad++;
            $display("FAIL rand_cycle%0d got v=%b a=%b gs=%b eo=%b exp v=%b a=%b gs=%b eo=%b",
                     k, VALID, A_L, GS_L, EO_L, m_valid, exp_al, m_gs, m_eo);
         end
      end
      RESET = 0; ACK = 0; EI_L = 0; I_L = 8'hFF;
   endtask

   initial begin
      test_reset();
      test_priority();
      test_hold_release();
      test_enable();
      test_back_to_back();
      test_reset_in_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
